// File: rtl/magnitude_comparator_pkg.sv
// Shared encodings for the sequential magnitude comparator: FSM states and
// the 3-bit result bus {eq, gt, lt}.
package magnitude_comparator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] EQ       = 3'b100;
    localparam logic [2:0] GT       = 3'b010;
    localparam logic [2:0] LT       = 3'b001;

    function automatic logic [2:0] slice_result(input logic eq, input logic gt, input logic lt);
        if (eq)      return EQ;
        else if (gt) return GT;
        else if (lt) return LT;
        else         return RES_NONE;
    endfunction

endpackage

// File: rtl/magnitude_comparator_slice.sv
// Unsigned compare of one SLICE-bit operand pair; purely combinational.
module magnitude_comparator_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/magnitude_comparator_seq.sv
// Multi-cycle WIDTH-bit magnitude comparator: one SLICE-bit slice per clock,
// MSB slice first, finishing early at the first unequal slice.
module magnitude_comparator_seq
    import magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             saida_e,
    output logic             saida_plus,
    output logic             saida_less
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}} >> 0;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NSLICE - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       res_q, res_d;
    logic             done_q, done_d;

    logic [SLICE-1:0] a_sl [NSLICE];
    logic [SLICE-1:0] b_sl [NSLICE];
    logic [SLICE-1:0] a_cur, b_cur;
    logic             cmp_eq, cmp_gt, cmp_lt;
    logic [WIDTH-1:0] sign_flip;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign a_sl[gi] = a_q[gi*SLICE +: SLICE];
            assign b_sl[gi] = b_q[gi*SLICE +: SLICE];
        end
    endgenerate

    assign a_cur = a_sl[idx_q];
    assign b_cur = b_sl[idx_q];

    magnitude_comparator_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a  (a_cur),
        .b  (b_cur),
        .eq (cmp_eq),
        .gt (cmp_gt),
        .lt (cmp_lt)
    );

    // Flipping the sign bit of both operands maps two's complement onto
    // offset binary, so the unsigned slice compare yields the signed order.
    assign sign_flip = signed_mode ? MSB_MASK : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A ^ sign_flip;
                    b_d     = B ^ sign_flip;
                    idx_d   = IDX_TOP;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!cmp_eq || idx_q == '0) begin
                    res_d   = slice_result(cmp_eq, cmp_gt, cmp_lt);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= RES_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign saida_e    = res_q[2];
    assign saida_plus = res_q[1];
    assign saida_less = res_q[0];

endmodule

// File: tb/tb_magnitude_comparator_seq.sv
// Self-checking bench for magnitude_comparator_seq (WIDTH=16, SLICE=4) using
// directed scenarios plus randomized operands against an arithmetic model.
module tb_magnitude_comparator_seq;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk;
    logic             rst;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             saida_e;
    logic             saida_plus;
    logic             saida_less;

    int tests_run;
    int tests_failed;

    magnitude_comparator_seq #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_mode(signed_mode),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .saida_e    (saida_e),
        .saida_plus (saida_plus),
        .saida_less (saida_less)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: expected {eq, gt, lt} from plain signed/unsigned arithmetic.
    function automatic logic [2:0] model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic sm);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = a;
        sb = b;
        if (a == b) return 3'b100;
        if (sm) return (sa > sb) ? 3'b010 : 3'b001;
        return (a > b) ? 3'b010 : 3'b001;
    endfunction

    // Reference: cycles from the accepting edge to done = leading equal slices + 2,
    // capped at NSLICE+1 when every slice matches.
    function automatic int model_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int j;
        int mask;
        j = 0;
        mask = (1 << SLICE) - 1;
        for (int s = NSLICE - 1; s >= 0; s--) begin
            if (((int'(a) >> (s * SLICE)) & mask) == ((int'(b) >> (s * SLICE)) & mask)) j++;
            else break;
        end
        return (j >= NSLICE) ? NSLICE + 1 : j + 2;
    endfunction

    // Stimulus: present one request, then watch for done (bounded). Returns the
    // observed latency (-1 on timeout), result bits, busy at done, and whether
    // busy dropped before done. junk_start keeps start high with new operands.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm,
                          input bit junk_start, input logic [WIDTH-1:0] ja, input logic [WIDTH-1:0] jb,
                          output int lat, output logic [2:0] res, output logic busy_at_done,
                          output bit busy_dropped);
        A = a;
        B = b;
        signed_mode = sm;
        start = 1'b1;
        tick();
        start = junk_start;
        A = ja;
        B = jb;
        signed_mode = ~sm;
        lat = -1;
        res = 3'bxxx;
        busy_at_done = 1'bx;
        busy_dropped = 1'b0;
        for (int c = 1; c <= 3 * NSLICE + 4; c++) begin
            if (done === 1'b1) begin
                lat = c;
                res = {saida_e, saida_plus, saida_less};
                busy_at_done = busy;
                start = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_dropped = 1'b1;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        A = 16'h0001;
        B = 16'h0000;
        signed_mode = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({busy, done, saida_e, saida_plus, saida_less} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got %b want 00000", {busy, done, saida_e, saida_plus, saida_less});
        end
        start = 1'b0;
        rst = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_start_ignored busy got %b want 0", busy);
        end
        $display("[TB] reset: outputs=%b", {busy, done, saida_e, saida_plus, saida_less});
    endtask

    task automatic test_equal();
        int lat;
        logic [2:0] res;
        logic bad;
        bit drop;
        launch(16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, lat, res, bad, drop);
        tests_run++;
        if (lat !== 5 || drop) begin
            tests_failed++;
            $display("FAIL equal_latency got %0d (busy_dropped=%0d) want 5", lat, drop);
        end
        tests_run++;
        if (res !== 3'b100 || bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL equal_result got res=%b busy=%b want res=100 busy=0", res, bad);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if ({done, saida_e, saida_plus, saida_less} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL equal_held got %b want 0100", {done, saida_e, saida_plus, saida_less});
        end
        $display("[TB] equal 1234/1234: lat=%0d res=%b", lat, res);
    endtask

    task automatic test_msb();
        int lat;
        logic [2:0] res;
        logic bad;
        bit drop;
        for (int m = 0; m < 2; m++) begin
            launch(16'h8000, 16'h7FFF, 1'(m), 1'b0, 16'h0, 16'h0, lat, res, bad, drop);
            tests_run++;
            if (lat !== 2 || res !== (m == 0 ? 3'b010 : 3'b001)) begin
                tests_failed++;
                $display("FAIL msb_mode%0d got lat=%0d res=%b want lat=2 res=%b", m, lat, res,
                         (m == 0 ? 3'b010 : 3'b001));
            end
            $display("[TB] 8000/7FFF signed=%0d: lat=%0d res=%b", m, lat, res);
            tick();
        end
    endtask

    task automatic test_early_exit();
        int lat;
        logic [2:0] res;
        logic bad;
        bit drop;
        launch(16'h12F0, 16'h12E0, 1'b0, 1'b0, 16'h0, 16'h0, lat, res, bad, drop);
        tests_run++;
        if (lat !== 4 || res !== 3'b010) begin
            tests_failed++;
            $display("FAIL early_exit_unsigned got lat=%0d res=%b want lat=4 res=010", lat, res);
        end
        $display("[TB] 12F0/12E0 unsigned: lat=%0d res=%b", lat, res);
        tick();
        launch(16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 16'h0, 16'h0, lat, res, bad, drop);
        tests_run++;
        if (lat !== 5 || res !== 3'b010) begin
            tests_failed++;
            $display("FAIL early_exit_signed got lat=%0d res=%b want lat=5 res=010", lat, res);
        end
        $display("[TB] FFFF/FFFE signed: lat=%0d res=%b", lat, res);
        tick();
    endtask

    task automatic test_start_while_busy();
        int lat;
        logic [2:0] res;
        logic bad;
        bit drop;
        launch(16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 16'h0000, lat, res, bad, drop);
        tests_run++;
        if (lat !== 5 || res !== 3'b001) begin
            tests_failed++;
            $display("FAIL busy_start_ignored got lat=%0d res=%b want lat=5 res=001", lat, res);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_start_no_retrigger got busy=%b done=%b want 0 0", busy, done);
        end
        $display("[TB] 0001/0002 with start held: lat=%0d res=%b", lat, res);
    endtask

    task automatic test_reset_during_run();
        int lat;
        logic [2:0] res;
        logic bad;
        bit drop;
        bit saw_done;
        A = 16'hABCD;
        B = 16'hABCD;
        signed_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({busy, done, saida_e, saida_plus, saida_less} !== 5'b0) begin
            tests_failed++;
            $display("FAIL rst_abort got %b want 00000", {busy, done, saida_e, saida_plus, saida_less});
        end
        saw_done = 1'b0;
        for (int c = 0; c < NSLICE + 2; c++) begin
            tick();
            if (done !== 1'b0) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done) begin
            tests_failed++;
            $display("FAIL rst_no_done got done pulse want none");
        end
        launch(16'h0100, 16'h00FF, 1'b1, 1'b0, 16'h0, 16'h0, lat, res, bad, drop);
        tests_run++;
        if (lat !== 3 || res !== 3'b010) begin
            tests_failed++;
            $display("FAIL rst_recover got lat=%0d res=%b want lat=3 res=010", lat, res);
        end
        $display("[TB] reset mid-run then 0100/00FF: lat=%0d res=%b", lat, res);
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [2:0] res;
        logic bad;
        bit drop;
        launch(16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, lat, res, bad, drop);
        tests_run++;
        if (lat !== 5 || res !== 3'b100) begin
            tests_failed++;
            $display("FAIL b2b_first got lat=%0d res=%b want lat=5 res=100", lat, res);
        end
        // Still inside the done cycle: the next request is accepted at the coming edge.
        launch(16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, lat, res, bad, drop);
        tests_run++;
        if (lat !== 5 || res !== 3'b001 || drop) begin
            tests_failed++;
            $display("FAIL b2b_second got lat=%0d res=%b busy_dropped=%0d want lat=5 res=001 busy_dropped=0",
                     lat, res, drop);
        end
        $display("[TB] back-to-back 0000/0001: lat=%0d res=%b", lat, res);
        tick();
    endtask

    task automatic test_random();
        int lat;
        int exp_lat;
        logic [2:0] res;
        logic [2:0] exp_res;
        logic bad;
        bit drop;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] keep_mask;
        logic sm;
        int keep;
        for (int n = 0; n < 150; n++) begin
            a = WIDTH'($urandom);
            keep = $urandom_range(0, NSLICE);
            keep_mask = (keep == 0) ? '0 : WIDTH'(((1 << (keep * SLICE)) - 1) << ((NSLICE - keep) * SLICE));
            b = (a & keep_mask) | (WIDTH'($urandom) & ~keep_mask);
            sm = 1'($urandom);
            exp_res = model_res(a, b, sm);
            exp_lat = model_lat(a, b);
            launch(a, b, sm, 1'($urandom), WIDTH'($urandom), WIDTH'($urandom), lat, res, bad, drop);
            tests_run++;
            if (lat !== exp_lat || res !== exp_res || bad !== 1'b0 || drop) begin
                tests_failed++;
                $display("FAIL random_%0d A=%h B=%h s=%0d got lat=%0d res=%b want lat=%0d res=%b",
                         n, a, b, sm, lat, res, exp_lat, exp_res);
            end else begin
                $display("[TB] random A=%h B=%h s=%0d: lat=%0d res=%b", a, b, sm, lat, res);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        A = '0;
        B = '0;
        test_reset();
        test_equal();
        test_msb();
        test_early_exit();
        test_start_while_busy();
        test_reset_during_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
